rr_arb_mux_4_1: RTL and testbench
=================================

RR_ARB_MUX_4_1 -- requirements
Module: rr_arb_mux_4_1

Interface
REQ-001 Parameter: CNT_W, default 8, width of the transfer counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  4  per-channel valid; req[i] qualifies di.
REQ-005 Port: d0, d1, d2, d3  input  4 each  channel data.
REQ-006 Port: gnt  output  4  one-hot accept strobe, combinational; gnt[i]=1 means di is taken this cycle.
REQ-007 Port: out_valid  output  1  output register holds a word.
REQ-008 Port: out_ready  input  1  downstream accepts when high with out_valid.
REQ-009 Port: out_data  output  4  registered selected word.
REQ-010 Port: out_sel  output  2  registered index of the channel that supplied out_data.
REQ-011 Port: xfer_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-012 The block SHALL hold a two-state FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-013 Slot is free when state is EMPTY, or FULL with out_ready=1 (same-cycle drain and refill).
REQ-014 When the slot is free and req!=0, the block SHALL grant exactly one channel: the first requesting index searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-015 When the slot is not free or req==0, gnt SHALL be 0.
REQ-016 On a grant to channel i, at the next edge: out_data<=di, out_sel<=i, ptr<=i, state<=FULL.
REQ-017 Latency SHALL be 1 cycle from gnt to out_valid; throughput SHALL be 1 word/cycle with out_ready held high.
REQ-018 Drain without refill (FULL, out_ready=1, no grant) SHALL move to EMPTY; out_data/out_sel keep their last values.
REQ-019 While FULL and out_ready=0, out_data, out_sel, and out_valid SHALL stay stable and ptr SHALL not change.
REQ-020 Data selection SHALL go through the 4-bit 4:1 mux driven by the combinational grant index.
REQ-021 xfer_cnt SHALL increment by 1 on every cycle where out_valid & out_ready, wrapping from 2^CNT_W-1 to 0.
REQ-022 A single requester held high SHALL be granted every free cycle; ptr never starves any active channel (max wait 3 grants).
REQ-023 req changing while the slot is busy SHALL have no effect until the slot is free.

Reset
REQ-024 On rst=1 at a clock edge: state=EMPTY, out_valid=0, out_data=0, out_sel=0, ptr=3, xfer_cnt=0.
REQ-025 While rst=1, gnt SHALL be 0 regardless of req.
REQ-026 Reset asserted mid-transfer SHALL discard the held word without counting it.
REQ-027 On the first free cycle after reset, channel 0 SHALL have highest priority.

Structure
REQ-028 A shared package SHALL hold N_CH=4, SEL_W=2, DATA_W=4, and the FSM state enum.
REQ-029 The data path SHALL instantiate the existing mux_4_1 as its one sub-module; the arbiter, FSM, and counter live in rr_arb_mux_4_1.

Verification
REQ-030 Reset, then req=4'b1111, d0..d3=1,2,3,4, out_ready=1 -> gnt cycles 0001, 0010, 0100, 1000; out_data 1,2,3,4 on consecutive cycles; out_sel 0,1,2,3.
REQ-031 req=4'b0100, d2=4'hA, out_ready=0 for 3 cycles -> one gnt pulse; out_data=A and out_valid held 3 cycles; then ready=1 -> xfer_cnt=1, gnt[2] may re-fire the same cycle.
REQ-032 After a grant to ch3, req=4'b1001 -> next grant ch0; after that, ch3.
REQ-033 Stream 256 words with CNT_W=8 -> xfer_cnt wraps to 0.
REQ-034 rst pulse while FULL with ready=0 -> next cycle out_valid=0, out_data=0, xfer_cnt unchanged at 0, ptr=3.
REQ-035 req=0 for 5 cycles after EMPTY -> gnt=0 and out_valid=0 throughout.

Source files
------------

// File: rtl/rr_arb_mux_4_1_pkg.sv
// Shared constants and FSM state type for the 4-channel round-robin arbiter/mux.
package rr_arb_mux_4_1_pkg;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 4;

    // Output slot occupancy
    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb_mux_4_1_mux.sv
// Plain 4:1 data multiplexer, binary select.
module mux_4_1
    import rr_arb_mux_4_1_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [DATA_W-1:0] y
);

    // Select one of the four channel words
    always_comb begin
        unique case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter feeding a single registered output slot with valid/ready drain.
module rr_arb_mux_4_1
    import rr_arb_mux_4_1_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [N_CH-1:0]   gnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic [CNT_W-1:0]  xfer_cnt
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q;
    logic [SEL_W-1:0]    gnt_idx;
    logic [SEL_W-1:0]    cand;
    logic                grant_any;
    logic                slot_free;
    logic                hs;
    logic [DATA_W-1:0]   mux_y;
    logic [DATA_W-1:0]   out_data_q;
    logic [SEL_W-1:0]    out_sel_q;
    logic [CNT_W-1:0]    cnt_q;

    assign out_valid = (state_q == StFull);
    assign hs        = out_valid && out_ready;
    // A full slot that is draining this cycle can be refilled in the same cycle
    assign slot_free = (state_q == StEmpty) || out_ready;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        grant_any = 1'b0;
        gnt_idx   = ptr_q;
        cand      = '0;
        if (!rst && slot_free) begin
            for (int unsigned k = 1; k <= N_CH; k++) begin
                cand = ptr_q + SEL_W'(k);
                if (req[cand] && !grant_any) begin
                    grant_any = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
        gnt = grant_any ? (N_CH'(1) << gnt_idx) : '0;
    end

    mux_4_1 u_mux (
        .sel (gnt_idx),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y   (mux_y)
    );

    // Slot FSM next state: a grant always fills, a drain without grant empties
    always_comb begin
        state_d = state_q;
        if (grant_any) begin
            state_d = StFull;
        end else if (hs) begin
            state_d = StEmpty;
        end
    end

    // Slot FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word, source index and arbitration pointer; only move on a grant
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_sel_q  <= '0;
            ptr_q      <= SEL_W'(N_CH - 1);
        end else if (grant_any) begin
            out_data_q <= mux_y;
            out_sel_q  <= gnt_idx;
            ptr_q      <= gnt_idx;
        end
    end

    // Completed output handshakes, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (hs) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_data = out_data_q;
    assign out_sel  = out_sel_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Self-checking bench for rr_arb_mux_4_1: behavioural model plus scoreboard of expected words.
module tb_rr_arb_mux_4_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       out_ready = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] dval [4];
    logic [3:0] gnt;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic [7:0] xfer_cnt;

    // Model state
    logic       m_full = 1'b0;
    logic [1:0] m_ptr  = 2'd3;
    logic [1:0] m_sel  = 2'd0;
    logic [3:0] m_data = 4'd0;
    logic [7:0] m_cnt  = 8'd0;
    logic [5:0] sb [$];
    logic [3:0] e_gnt;
    logic [1:0] e_idx;
    logic       e_hs;
    logic       cur_rst;
    logic [5:0] exp_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_arb_mux_4_1 #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d0        (dval[0]),
        .d1        (dval[1]),
        .d2        (dval[2]),
        .d3        (dval[3]),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .xfer_cnt  (xfer_cnt)
    );

    // Apply inputs (just after a falling edge) and predict the combinational grant
    task automatic drive(input logic [3:0] r, input logic rdy, input logic rs);
        logic [1:0] i;
        req = r;
        out_ready = rdy;
        rst = rs;
        cur_rst = rs;
        #1;
        e_gnt = 4'b0;
        e_idx = 2'd0;
        if (!rs && (!m_full || rdy) && r != 4'b0) begin
            for (int k = 1; k <= 4; k++) begin
                i = m_ptr + 2'(k);
                if (r[i] && e_gnt == 4'b0) begin
                    e_gnt[i] = 1'b1;
                    e_idx = i;
                end
            end
        end
        e_hs = !rs && m_full && rdy;
    endtask

    // Clock the DUT and update the model; returns at the following falling edge
    task automatic advance();
        @(posedge clk);
        if (cur_rst) begin
            m_full = 1'b0;
            m_ptr  = 2'd3;
            m_cnt  = 8'd0;
            m_data = 4'd0;
            m_sel  = 2'd0;
            sb.delete();
        end else begin
            if (e_hs) m_cnt = m_cnt + 8'd1;
            if (e_gnt != 4'b0) begin
                m_full = 1'b1;
                m_ptr  = e_idx;
                m_sel  = e_idx;
                m_data = dval[e_idx];
                sb.push_back({e_idx, dval[e_idx]});
            end else if (e_hs) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Table entries are {rst, out_ready, req}
    task automatic test_reset();
        logic [5:0] st [3] = '{6'b1_1_1111, 6'b1_0_0101, 6'b1_1_1111};
        for (int c = 0; c < 3; c++) begin
            drive(st[c][3:0], st[c][4], st[c][5]);
            n_cmp++;
            if (gnt !== e_gnt) begin
                n_bad++; $display("FAIL reset_gnt c%0d: got %b want %b", c, gnt, e_gnt);
            end
            advance();
            n_cmp++;
            if ({out_valid, out_sel, out_data, xfer_cnt} !== {1'b0, 2'd0, 4'd0, 8'd0}) begin
                n_bad++;
                $display("FAIL reset_state c%0d: got v=%b s=%0d d=%h c=%0d want all zero",
                         c, out_valid, out_sel, out_data, xfer_cnt);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] st [6] = '{6'b1_1_0000, 6'b0_1_1111, 6'b0_1_1111, 6'b0_1_1111,
                               6'b0_1_1111, 6'b0_1_0000};
        logic [3:0] want_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int k = 0; k < 4; k++) dval[k] = 4'(k + 1);
        for (int c = 0; c < 6; c++) begin
            drive(st[c][3:0], st[c][4], st[c][5]);
            n_cmp++;
            if (gnt !== e_gnt) begin
                n_bad++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, e_gnt);
            end
            if (c >= 1 && c <= 4) begin
                n_cmp++;
                if (gnt !== want_g[c-1]) begin
                    n_bad++; $display("FAIL rr_seq c%0d: got %b want %b", c, gnt, want_g[c-1]);
                end
            end
            if (e_hs && sb.size() > 0) begin
                exp_w = sb.pop_front();
                n_cmp++;
                if ({out_sel, out_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL rr_word c%0d: got sel=%0d data=%h want sel=%0d data=%h",
                             c, out_sel, out_data, exp_w[5:4], exp_w[3:0]);
                end
            end
            advance();
            n_cmp++;
            if ({out_valid, out_sel, out_data, xfer_cnt} !== {m_full, m_sel, m_data, m_cnt}) begin
                n_bad++;
                $display("FAIL rr_state c%0d: got v=%b s=%0d d=%h c=%0d want v=%b s=%0d d=%h c=%0d",
                         c, out_valid, out_sel, out_data, xfer_cnt, m_full, m_sel, m_data, m_cnt);
            end
        end
    endtask

    // Includes a req change while the slot is busy, which must be ignored
    task automatic test_backpressure();
        logic [5:0] st [7] = '{6'b1_0_0000, 6'b0_0_0100, 6'b0_0_0100, 6'b0_0_1111,
                               6'b0_0_0100, 6'b0_1_0100, 6'b0_1_0000};
        dval[2] = 4'hA;
        for (int c = 0; c < 7; c++) begin
            drive(st[c][3:0], st[c][4], st[c][5]);
            n_cmp++;
            if (gnt !== e_gnt) begin
                n_bad++; $display("FAIL bp_gnt c%0d: got %b want %b", c, gnt, e_gnt);
            end
            if (e_hs && sb.size() > 0) begin
                exp_w = sb.pop_front();
                n_cmp++;
                if ({out_sel, out_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL bp_word c%0d: got sel=%0d data=%h want sel=%0d data=%h",
                             c, out_sel, out_data, exp_w[5:4], exp_w[3:0]);
                end
            end
            advance();
            n_cmp++;
            if ({out_valid, out_sel, out_data, xfer_cnt} !== {m_full, m_sel, m_data, m_cnt}) begin
                n_bad++;
                $display("FAIL bp_state c%0d: got v=%b s=%0d d=%h c=%0d want v=%b s=%0d d=%h c=%0d",
                         c, out_valid, out_sel, out_data, xfer_cnt, m_full, m_sel, m_data, m_cnt);
            end
        end
        n_cmp++;
        if (xfer_cnt !== 8'd2) begin
            n_bad++; $display("FAIL bp_count: got %0d want 2", xfer_cnt);
        end
    endtask

    task automatic test_priority_rotate();
        logic [5:0] st [6] = '{6'b0_1_1000, 6'b0_1_1001, 6'b0_1_1001, 6'b0_1_1001,
                               6'b0_1_0000, 6'b0_1_0000};
        for (int k = 0; k < 4; k++) dval[k] = 4'(4'hC + k);
        for (int c = 0; c < 6; c++) begin
            drive(st[c][3:0], st[c][4], st[c][5]);
            n_cmp++;
            if (gnt !== e_gnt) begin
                n_bad++; $display("FAIL prio_gnt c%0d: got %b want %b", c, gnt, e_gnt);
            end
            if (e_hs && sb.size() > 0) begin
                exp_w = sb.pop_front();
                n_cmp++;
                if ({out_sel, out_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL prio_word c%0d: got sel=%0d data=%h want sel=%0d data=%h",
                             c, out_sel, out_data, exp_w[5:4], exp_w[3:0]);
                end
            end
            advance();
            n_cmp++;
            if ({out_valid, out_sel, out_data, xfer_cnt} !== {m_full, m_sel, m_data, m_cnt}) begin
                n_bad++;
                $display("FAIL prio_state c%0d: got v=%b s=%0d d=%h c=%0d want v=%b s=%0d d=%h c=%0d",
                         c, out_valid, out_sel, out_data, xfer_cnt, m_full, m_sel, m_data, m_cnt);
            end
        end
    endtask

    // 257 streaming cycles give exactly 256 handshakes
    task automatic test_counter_wrap();
        drive(4'b0, 1'b0, 1'b1);
        advance();
        for (int c = 0; c < 258; c++) begin
            for (int k = 0; k < 4; k++) dval[k] = 4'($urandom_range(0, 15));
            drive((c < 257) ? 4'b1111 : 4'b0000, 1'b1, 1'b0);
            n_cmp++;
            if (gnt !== e_gnt) begin
                n_bad++; $display("FAIL wrap_gnt c%0d: got %b want %b", c, gnt, e_gnt);
            end
            if (e_hs && sb.size() > 0) begin
                exp_w = sb.pop_front();
                n_cmp++;
                if ({out_sel, out_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL wrap_word c%0d: got sel=%0d data=%h want sel=%0d data=%h",
                             c, out_sel, out_data, exp_w[5:4], exp_w[3:0]);
                end
            end
            advance();
            n_cmp++;
            if ({out_valid, out_sel, out_data, xfer_cnt} !== {m_full, m_sel, m_data, m_cnt}) begin
                n_bad++;
                $display("FAIL wrap_state c%0d: got v=%b c=%0d want v=%b c=%0d",
                         c, out_valid, xfer_cnt, m_full, m_cnt);
            end
            if (c == 256) begin
                n_cmp++;
                if (xfer_cnt !== 8'd0) begin
                    n_bad++; $display("FAIL wrap_zero: got %0d want 0", xfer_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] st [6] = '{6'b1_0_0000, 6'b0_0_0010, 6'b0_0_0010, 6'b1_0_1111,
                               6'b0_1_1111, 6'b0_1_0000};
        for (int k = 0; k < 4; k++) dval[k] = 4'(4'h5 + k);
        for (int c = 0; c < 6; c++) begin
            drive(st[c][3:0], st[c][4], st[c][5]);
            n_cmp++;
            if (gnt !== e_gnt) begin
                n_bad++; $display("FAIL rmid_gnt c%0d: got %b want %b", c, gnt, e_gnt);
            end
            if (c == 4) begin
                n_cmp++;
                if (gnt !== 4'b0001) begin
                    n_bad++; $display("FAIL rmid_first_ch0: got %b want 0001", gnt);
                end
            end
            if (e_hs && sb.size() > 0) begin
                exp_w = sb.pop_front();
                n_cmp++;
                if ({out_sel, out_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL rmid_word c%0d: got sel=%0d data=%h want sel=%0d data=%h",
                             c, out_sel, out_data, exp_w[5:4], exp_w[3:0]);
                end
            end
            advance();
            n_cmp++;
            if ({out_valid, out_sel, out_data, xfer_cnt} !== {m_full, m_sel, m_data, m_cnt}) begin
                n_bad++;
                $display("FAIL rmid_state c%0d: got v=%b s=%0d d=%h c=%0d want v=%b s=%0d d=%h c=%0d",
                         c, out_valid, out_sel, out_data, xfer_cnt, m_full, m_sel, m_data, m_cnt);
            end
            if (c == 3) begin
                n_cmp++;
                if ({out_valid, out_data, xfer_cnt} !== {1'b0, 4'd0, 8'd0}) begin
                    n_bad++;
                    $display("FAIL rmid_discard: got v=%b d=%h c=%0d want v=0 d=0 c=0",
                             out_valid, out_data, xfer_cnt);
                end
            end
        end
    endtask

    task automatic test_idle();
        logic [5:0] st [5] = '{6'b0_1_0000, 6'b0_0_0000, 6'b0_1_0000, 6'b0_0_0000,
                               6'b0_1_0000};
        for (int c = 0; c < 5; c++) begin
            drive(st[c][3:0], st[c][4], st[c][5]);
            n_cmp++;
            if (gnt !== 4'b0) begin
                n_bad++; $display("FAIL idle_gnt c%0d: got %b want 0000", c, gnt);
            end
            advance();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL idle_valid c%0d: got %b want 0", c, out_valid);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) dval[k] = 4'd0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_backpressure();
        test_priority_rotate();
        test_counter_wrap();
        test_reset_mid();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
